// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount word enumerator and its checkers.
// Helpers work on a fixed maximum width so that any instance width W <= MAXW can use them.
package popcount_pkg;

    localparam int unsigned MAXW = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index of the lowest set bit among the low w bits; w when none is set.
    function automatic int unsigned ctz(input logic [MAXW-1:0] x, input int unsigned w);
        int unsigned n;
        logic        found;
        n     = w;
        found = 1'b0;
        for (int unsigned i = 0; i < MAXW; i++) begin
            if (!found && (i < w) && x[i]) begin
                n     = i;
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Smallest word with popcount k: k ones packed at the bottom.
    function automatic logic [MAXW-1:0] first_word(input int unsigned k);
        logic [MAXW-1:0] fw;
        for (int unsigned i = 0; i < MAXW; i++) begin
            fw[i] = (i < k);
        end
        return fw;
    endfunction

    // Largest w-bit word with popcount k: k ones packed at the top.
    function automatic logic [MAXW-1:0] final_word(input int unsigned k, input int unsigned w);
        logic [MAXW-1:0] fw;
        for (int unsigned i = 0; i < MAXW; i++) begin
            fw[i] = (i < w) && ((i + k) >= w);
        end
        return fw;
    endfunction

endpackage

// File: rtl/popcount_enum_if.sv
// Output stream of the enumerator. Valid/ready: a word transfers on any rising edge where
// out_valid and out_ready are both high; once raised, out_valid and the payload hold until then.
interface popcount_enum_if #(
    parameter int W  = 3,
    parameter int IW = 16
);
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic          out_last;
    logic [IW-1:0] out_idx;

    modport master (
        output out_valid,
        output out_word,
        output out_last,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_word,
        input  out_last,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/popcount_next.sv
// Combinational successor: the next larger W-bit word with the same popcount (Gosper's hack).
// The division by the lowest set bit is replaced by an extra right shift of its position.
module popcount_next
    import popcount_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_next
);
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] w_t;
    logic [W-1:0]  w_low;
    logic [W-1:0]  w_r;
    logic [W-1:0]  w_diff;
    int unsigned   w_sh;

    assign w_t    = CW'(ctz(MAXW'(i_x), W));
    assign w_low  = i_x & (~i_x + W'(1));
    assign w_r    = i_x + w_low;
    assign w_diff = w_r ^ i_x;
    assign w_sh   = 32'(w_t) + 32'd2;
    assign o_next = w_r | (w_diff >> w_sh);

endmodule

// File: rtl/popcount_enum.sv
// Streams every W-bit word with popcount k in ascending order, one per accepted handshake.
// Holds the FSM, the output registers and the index counter; the successor is a sub-module.
module popcount_enum
    import popcount_pkg::*;
#(
    parameter int  W  = 3,
    parameter int  IW = 16,
    localparam int CW = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            start,
    input  logic [CW-1:0]   k,
    popcount_enum_if.master o_bus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output state_t          dbg_state
);
    state_t        r_state;
    logic          r_valid;
    logic [W-1:0]  r_word;
    logic          r_last;
    logic [IW-1:0] r_idx;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [W-1:0]  r_final;

    logic [W-1:0]  w_next;
    logic [W-1:0]  w_first;
    logic [W-1:0]  w_final;
    logic          w_fire;

    popcount_next #(.W(W)) u_next (
        .i_x    (r_word),
        .o_next (w_next)
    );

    assign w_first = W'(first_word(32'(k)));
    assign w_final = W'(final_word(32'(k), W));
    assign w_fire  = r_valid && o_bus.out_ready;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_final <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (k > CW'(W)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b1;
                            r_word  <= w_first;
                            r_idx   <= '0;
                            r_final <= w_final;
                            r_last  <= (w_first == w_final);
                        end
                    end
                end
                RUN: begin
                    // Word and index are left at their final values after the last transfer.
                    if (w_fire) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_word <= w_next;
                            r_idx  <= r_idx + IW'(1);
                            r_last <= (w_next == r_final);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_bus.out_valid = r_valid;
    assign o_bus.out_word  = r_word;
    assign o_bus.out_last  = r_last;
    assign o_bus.out_idx   = r_idx;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign dbg_state       = r_state;

endmodule
